// File: rtl/a_packet_pkg.sv
// Shared packet definitions for the A2B link: field widths, length codes,
// packetiser FSM states and the header builder.
package a_packet_pkg;

    localparam int PACKET_TYPE_WIDTH   = 4;
    localparam int PACKET_LENGTH_WIDTH = 4;

    localparam logic [PACKET_LENGTH_WIDTH-1:0] PACKET_LENGTH_257  = 4'd1;
    localparam logic [PACKET_LENGTH_WIDTH-1:0] PACKET_LENGTH_514  = 4'd2;
    localparam logic [PACKET_LENGTH_WIDTH-1:0] PACKET_LENGTH_771  = 4'd3;
    localparam logic [PACKET_LENGTH_WIDTH-1:0] PACKET_LENGTH_1028 = 4'd4;

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        WAIT_BRAM     = 4'd1,
        WRITE_HEADER  = 4'd2,
        WRITE_PAYLOAD = 4'd3,
        MSG_READY     = 4'd4,
        WAIT_TAKEN    = 4'd5
    } pp_state_t;

    // Short packets carry their exact depth; long packets are implied by the length code.
    function automatic logic [31:0] build_header(input logic [PACKET_TYPE_WIDTH-1:0] ptype,
                                                 input logic [10:0] depth);
        logic [PACKET_LENGTH_WIDTH-1:0] code;
        logic [8:0] len;
        code = PACKET_LENGTH_1028;
        len  = '0;
        if (depth <= 11'd256) begin
            code = PACKET_LENGTH_257;
            len  = depth[8:0];
        end else if (depth == 11'd512) begin
            code = PACKET_LENGTH_514;
        end else if (depth == 11'd768) begin
            code = PACKET_LENGTH_771;
        end
        return {ptype, code, len, 15'd0};
    endfunction

endpackage

// File: rtl/a_packet_fsm.sv
// Packetiser control FSM: sequences header/payload writes and the
// msg_stored / busy handshake with the network layer.
module a_packet_fsm
    import a_packet_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      accept,
    input  logic      busy_net,
    input  logic      payload_done,
    output pp_state_t state,
    output logic      idle,
    output logic      hdr_we,
    output logic      in_payload,
    output logic      busy_pp,
    output logic      msg_ready
);

    pp_state_t next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:          if (accept)       next_state = WAIT_BRAM;
            WAIT_BRAM:     if (!busy_net)    next_state = WRITE_HEADER;
            WRITE_HEADER:                    next_state = WRITE_PAYLOAD;
            WRITE_PAYLOAD: if (payload_done) next_state = MSG_READY;
            MSG_READY:     if (busy_net)     next_state = WAIT_TAKEN;
            WAIT_TAKEN:                      next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    assign idle       = (state == IDLE);
    assign hdr_we     = (state == WRITE_HEADER);
    assign in_payload = (state == WRITE_PAYLOAD);
    assign busy_pp    = (state == WAIT_BRAM) || (state == WRITE_HEADER) || (state == WRITE_PAYLOAD);
    assign msg_ready  = (state == MSG_READY);

endmodule

// File: rtl/a_packet.sv
// Alice-side TX packetiser: drains the er (32b) or sift (64b) FIFO into TX BRAM
// behind a header word, then hands the message to the network layer.
module a_packet
    import a_packet_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 11,
    parameter int MAX_DEPTH = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_type,
    input  logic                req_src,
    input  logic [ADDR_W-1:0]   req_depth,
    output logic                req_err,
    output logic                er_rd_en,
    input  logic [DATA_W-1:0]   er_dout,
    input  logic                er_empty,
    output logic                sift_rd_en,
    input  logic [2*DATA_W-1:0] sift_dout,
    input  logic                sift_empty,
    output logic                A_TX_bram_clka,
    output logic                A_TX_bram_ena,
    output logic                A_TX_bram_wea,
    output logic [ADDR_W-1:0]   A_TX_bram_addra,
    output logic [DATA_W-1:0]   A_TX_bram_dina,
    input  logic                busy_Net2PP_TX,
    output logic                msg_stored,
    output logic [ADDR_W-1:0]   sizeTX_msg,
    output logic                busy_PP2Net_TX,
    output logic [3:0]          A_packet_state
);

    pp_state_t          state;
    logic               idle, hdr_we, in_payload, msg_ready;
    logic               alive;
    logic [3:0]         type_q;
    logic               src_q;
    logic [ADDR_W-1:0]  depth_q, rd_cnt, wr_cnt;
    logic               pend_hi, pend_lo;
    logic [DATA_W-1:0]  lo_hold;
    logic               req_ok, accept, rd_allow, rd_fire, wr_fire, payload_done;

    // Long packets only come in the three fixed sizes; 64b sources need even depth.
    assign req_ok = (req_depth != '0)
                 && (req_depth <= ADDR_W'(MAX_DEPTH))
                 && ((req_depth <= ADDR_W'(256)) || (req_depth == ADDR_W'(512))
                     || (req_depth == ADDR_W'(768)) || (req_depth == ADDR_W'(1024)))
                 && !(req_src && req_depth[0]);

    assign req_ready = alive && idle;
    assign accept    = req_valid && req_ready && req_ok;

    // A 64b read yields two writes, so a new sift read waits out the upper-half write.
    assign rd_allow     = in_payload && (rd_cnt < depth_q);
    assign er_rd_en     = rd_allow && !src_q && !er_empty;
    assign sift_rd_en   = rd_allow && src_q && !sift_empty && !pend_hi;
    assign rd_fire      = er_rd_en || sift_rd_en;
    assign wr_fire      = pend_hi || pend_lo;
    assign payload_done = wr_fire && (wr_cnt == depth_q - ADDR_W'(1));

    a_packet_fsm u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .accept       (accept),
        .busy_net     (busy_Net2PP_TX),
        .payload_done (payload_done),
        .state        (state),
        .idle         (idle),
        .hdr_we       (hdr_we),
        .in_payload   (in_payload),
        .busy_pp      (busy_PP2Net_TX),
        .msg_ready    (msg_ready)
    );

    // Request latch, read/write counters and the FIFO-to-BRAM write pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive   <= 1'b0;
            req_err <= 1'b0;
            type_q  <= '0;
            src_q   <= 1'b0;
            depth_q <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            pend_hi <= 1'b0;
            pend_lo <= 1'b0;
            lo_hold <= '0;
        end else begin
            alive   <= 1'b1;
            req_err <= req_valid && req_ready && !req_ok;
            pend_hi <= rd_fire;
            pend_lo <= pend_hi && src_q;
            if (pend_hi && src_q)
                lo_hold <= sift_dout[DATA_W-1:0];
            if (accept) begin
                type_q  <= req_type;
                src_q   <= req_src;
                depth_q <= req_depth;
                rd_cnt  <= '0;
                wr_cnt  <= '0;
            end else begin
                if (rd_fire)
                    rd_cnt <= rd_cnt + (src_q ? ADDR_W'(2) : ADDR_W'(1));
                if (wr_fire)
                    wr_cnt <= wr_cnt + ADDR_W'(1);
            end
        end
    end

    assign A_TX_bram_clka  = clk;
    assign A_TX_bram_ena   = alive;
    assign A_TX_bram_wea   = hdr_we || wr_fire;
    assign A_TX_bram_addra = hdr_we  ? '0 :
                             wr_fire ? wr_cnt + ADDR_W'(1) : '0;
    assign A_TX_bram_dina  = hdr_we  ? build_header(type_q, depth_q) :
                             pend_hi ? (src_q ? sift_dout[2*DATA_W-1:DATA_W] : er_dout) :
                             pend_lo ? lo_hold : '0;

    assign msg_stored     = msg_ready;
    assign sizeTX_msg     = msg_ready ? depth_q + ADDR_W'(1) : '0;
    assign A_packet_state = state;

endmodule

// File: tb/tb_a_packet.sv
// Directed self-checking bench for a_packet with behavioural FIFO and BRAM models.
`timescale 1ns/1ps
module tb_a_packet;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_src, req_err;
    logic [3:0]  req_type;
    logic [10:0] req_depth;
    logic        er_rd_en, er_empty, sift_rd_en, sift_empty;
    logic [31:0] er_dout = '0;
    logic [63:0] sift_dout = '0;
    logic        bram_clka, bram_ena, bram_wea;
    logic [10:0] bram_addra;
    logic [31:0] bram_dina;
    logic        busy_net, msg_stored, busy_pp;
    logic [10:0] size_tx;
    logic [3:0]  pp_state;

    int assertCount = 0;
    int failCount   = 0;

    a_packet dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_type        (req_type),
        .req_src         (req_src),
        .req_depth       (req_depth),
        .req_err         (req_err),
        .er_rd_en        (er_rd_en),
        .er_dout         (er_dout),
        .er_empty        (er_empty),
        .sift_rd_en      (sift_rd_en),
        .sift_dout       (sift_dout),
        .sift_empty      (sift_empty),
        .A_TX_bram_clka  (bram_clka),
        .A_TX_bram_ena   (bram_ena),
        .A_TX_bram_wea   (bram_wea),
        .A_TX_bram_addra (bram_addra),
        .A_TX_bram_dina  (bram_dina),
        .busy_Net2PP_TX  (busy_net),
        .msg_stored      (msg_stored),
        .sizeTX_msg      (size_tx),
        .busy_PP2Net_TX  (busy_pp),
        .A_packet_state  (pp_state)
    );

    always #5 clk = ~clk;

    // FIFO models: write pointers advanced by the stimulus, read pointers by rd_en.
    logic [31:0] er_mem   [0:4095];
    logic [63:0] sift_mem [0:2047];
    logic [11:0] er_wp = '0, er_rp = '0;
    logic [10:0] sift_wp = '0, sift_rp = '0;
    int er_under = 0, sift_under = 0, er_rd_total = 0, sift_rd_total = 0;

    assign er_empty   = (er_rp == er_wp);
    assign sift_empty = (sift_rp == sift_wp);

    always @(posedge clk) begin
        if (er_rd_en) begin
            er_rd_total <= er_rd_total + 1;
            if (er_rp == er_wp) er_under <= er_under + 1;
            else begin
                er_dout <= er_mem[er_rp];
                er_rp   <= er_rp + 12'd1;
            end
        end
        if (sift_rd_en) begin
            sift_rd_total <= sift_rd_total + 1;
            if (sift_rp == sift_wp) sift_under <= sift_under + 1;
            else begin
                sift_dout <= sift_mem[sift_rp];
                sift_rp   <= sift_rp + 11'd1;
            end
        end
    end

    // BRAM model plus write-ordering monitor.
    logic [31:0] mem [0:2047];
    logic [10:0] last_addr = '0;
    int wr_total = 0, gap_err = 0, bad_wea = 0;

    always @(posedge clk) begin
        if (rst_n && bram_wea && bram_ena) begin
            mem[bram_addra] <= bram_dina;
            wr_total <= wr_total + 1;
            if (bram_addra == 11'd0) last_addr <= '0;
            else begin
                if (bram_addra != last_addr + 11'd1) gap_err <= gap_err + 1;
                last_addr <= bram_addra;
            end
            if (!(pp_state == 4'd2 || pp_state == 4'd3)) bad_wea <= bad_wea + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] t, input logic s, input logic [10:0] d);
        @(negedge clk);
        req_type  = t;
        req_src   = s;
        req_depth = d;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic pushEr(input logic [31:0] v);
        er_mem[er_wp] = v;
        er_wp = er_wp + 12'd1;
    endtask

    task automatic pushSift(input logic [63:0] v);
        sift_mem[sift_wp] = v;
        sift_wp = sift_wp + 11'd1;
    endtask

    task automatic waitMsg(output int cyc);
        cyc = 0;
        while (!msg_stored && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!msg_stored) checkOutput("msg_stored timeout", 64'(msg_stored), 64'd1);
    endtask

    task automatic finishHandshake(input string tag);
        busy_net = 1'b1;
        @(negedge clk);
        checkOutput({tag, " msg_stored cleared"}, 64'(msg_stored), 64'd0);
        checkOutput({tag, " size cleared"}, 64'(size_tx), 64'd0);
        checkOutput({tag, " wait_taken"}, 64'(pp_state), 64'd5);
        busy_net = 1'b0;
        @(negedge clk);
        checkOutput({tag, " back idle"}, 64'(req_ready), 64'd1);
    endtask

    int cyc, w0, r0, s0, w1, r1, bad;
    logic [10:0] bad_depth [0:3];
    logic        bad_src   [0:3];

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_type = '0; req_src = 1'b0; req_depth = '0; busy_net = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset wea", 64'(bram_wea), 64'd0);
        checkOutput("reset ena", 64'(bram_ena), 64'd0);
        checkOutput("reset msg_stored", 64'(msg_stored), 64'd0);
        checkOutput("reset size", 64'(size_tx), 64'd0);
        checkOutput("reset busy_pp", 64'(busy_pp), 64'd0);
        checkOutput("reset state", 64'(pp_state), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle req_ready", 64'(req_ready), 64'd1);

        $display("[TB] T1 er depth 5");
        for (int i = 1; i <= 5; i++) pushEr(32'(i));
        w0 = wr_total; r0 = er_rd_total;
        applyStimulus(4'hA, 1'b0, 11'd5);
        waitMsg(cyc);
        checkOutput("T1 latency", 64'(cyc), 64'd8);
        checkOutput("T1 header", 64'(mem[0]), 64'hA1028000);
        for (int i = 1; i <= 5; i++) checkOutput("T1 payload", 64'(mem[i]), 64'(i));
        checkOutput("T1 size", 64'(size_tx), 64'd6);
        checkOutput("T1 writes", 64'(wr_total - w0), 64'd6);
        checkOutput("T1 er reads", 64'(er_rd_total - r0), 64'd5);
        repeat (3) @(negedge clk);
        checkOutput("T1 msg held", 64'(msg_stored), 64'd1);
        finishHandshake("T1");

        $display("[TB] T2 sift depth 1024");
        for (int k = 0; k < 512; k++) pushSift({32'(2*k), 32'(2*k+1)});
        w0 = wr_total; s0 = sift_rd_total;
        applyStimulus(4'h3, 1'b1, 11'd1024);
        waitMsg(cyc);
        checkOutput("T2 latency", 64'(cyc), 64'd1027);
        checkOutput("T2 header", 64'(mem[0]), 64'h34000000);
        bad = -1;
        for (int i = 1; i <= 1024; i++) if (mem[i] !== 32'(i-1) && bad < 0) bad = i;
        if (bad < 0) bad = 1024;
        checkOutput("T2 payload", 64'(mem[bad]), 64'(bad-1));
        checkOutput("T2 sift reads", 64'(sift_rd_total - s0), 64'd512);
        checkOutput("T2 writes", 64'(wr_total - w0), 64'd1025);
        checkOutput("T2 size", 64'(size_tx), 64'd1025);
        finishHandshake("T2");

        $display("[TB] T3 rejects");
        bad_depth[0] = 11'd300;  bad_src[0] = 1'b0;
        bad_depth[1] = 11'd7;    bad_src[1] = 1'b1;
        bad_depth[2] = 11'd0;    bad_src[2] = 1'b0;
        bad_depth[3] = 11'd1025; bad_src[3] = 1'b0;
        w0 = wr_total;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h1, bad_src[i], bad_depth[i]);
            checkOutput("T3 req_err pulse", 64'(req_err), 64'd1);
            checkOutput("T3 stays idle", 64'(pp_state), 64'd0);
            @(negedge clk);
            checkOutput("T3 req_err drop", 64'(req_err), 64'd0);
        end
        checkOutput("T3 no writes", 64'(wr_total - w0), 64'd0);

        $display("[TB] T4 er stall");
        for (int i = 1; i <= 4; i++) pushEr(32'(100 + i));
        w0 = wr_total; r0 = er_rd_total;
        applyStimulus(4'h7, 1'b0, 11'd8);
        repeat (10) @(negedge clk);
        w1 = wr_total; r1 = er_rd_total;
        repeat (10) @(negedge clk);
        checkOutput("T4 gap writes", 64'(wr_total - w1), 64'd0);
        checkOutput("T4 gap reads", 64'(er_rd_total - r1), 64'd0);
        checkOutput("T4 gap state", 64'(pp_state), 64'd3);
        for (int i = 5; i <= 8; i++) pushEr(32'(100 + i));
        waitMsg(cyc);
        checkOutput("T4 header", 64'(mem[0]), 64'h71040000);
        for (int i = 1; i <= 8; i++) checkOutput("T4 payload", 64'(mem[i]), 64'(100 + i));
        checkOutput("T4 writes", 64'(wr_total - w0), 64'd9);
        checkOutput("T4 er reads", 64'(er_rd_total - r0), 64'd8);
        checkOutput("T4 size", 64'(size_tx), 64'd9);
        finishHandshake("T4");

        $display("[TB] T5 network busy at request");
        busy_net = 1'b1;
        pushSift(64'h00005555_00006666);
        w0 = wr_total;
        applyStimulus(4'h6, 1'b1, 11'd2);
        repeat (5) @(negedge clk);
        checkOutput("T5 wait_bram", 64'(pp_state), 64'd1);
        checkOutput("T5 no writes", 64'(wr_total - w0), 64'd0);
        checkOutput("T5 busy_pp", 64'(busy_pp), 64'd1);
        busy_net = 1'b0;
        @(negedge clk);
        checkOutput("T5 header wea", 64'(bram_wea), 64'd1);
        checkOutput("T5 header addr", 64'(bram_addra), 64'd0);
        checkOutput("T5 header data", 64'(bram_dina), 64'h61010000);
        waitMsg(cyc);
        checkOutput("T5 payload hi", 64'(mem[1]), 64'h5555);
        checkOutput("T5 payload lo", 64'(mem[2]), 64'h6666);
        finishHandshake("T5");

        $display("[TB] T7 er depth 256");
        for (int i = 0; i < 256; i++) pushEr(32'h1000 + 32'(i));
        applyStimulus(4'h2, 1'b0, 11'd256);
        waitMsg(cyc);
        checkOutput("T7 latency", 64'(cyc), 64'd259);
        checkOutput("T7 header", 64'(mem[0]), 64'h21800000);
        bad = -1;
        for (int i = 1; i <= 256; i++) if (mem[i] !== 32'h1000 + 32'(i-1) && bad < 0) bad = i;
        if (bad < 0) bad = 256;
        checkOutput("T7 payload", 64'(mem[bad]), 64'h1000 + 64'(bad-1));
        checkOutput("T7 size", 64'(size_tx), 64'd257);
        finishHandshake("T7");

        $display("[TB] T6 reset mid-payload");
        for (int i = 0; i < 8; i++) pushEr(32'h200 + 32'(i));
        applyStimulus(4'h9, 1'b0, 11'd8);
        repeat (4) @(negedge clk);
        checkOutput("T6 in payload", 64'(pp_state), 64'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("T6 reset wea", 64'(bram_wea), 64'd0);
        checkOutput("T6 reset rd_en", 64'(er_rd_en), 64'd0);
        checkOutput("T6 reset busy_pp", 64'(busy_pp), 64'd0);
        checkOutput("T6 reset state", 64'(pp_state), 64'd0);
        checkOutput("T6 reset req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pushSift(64'h00000011_00000022);
        pushSift(64'h00000033_00000044);
        s0 = sift_rd_total;
        applyStimulus(4'h5, 1'b1, 11'd4);
        waitMsg(cyc);
        checkOutput("T6 latency", 64'(cyc), 64'd7);
        checkOutput("T6 header", 64'(mem[0]), 64'h51020000);
        checkOutput("T6 payload 1", 64'(mem[1]), 64'h11);
        checkOutput("T6 payload 2", 64'(mem[2]), 64'h22);
        checkOutput("T6 payload 3", 64'(mem[3]), 64'h33);
        checkOutput("T6 payload 4", 64'(mem[4]), 64'h44);
        checkOutput("T6 sift reads", 64'(sift_rd_total - s0), 64'd2);
        checkOutput("T6 size", 64'(size_tx), 64'd5);
        finishHandshake("T6");

        checkOutput("address gaps", 64'(gap_err), 64'd0);
        checkOutput("stray wea", 64'(bad_wea), 64'd0);
        checkOutput("er over-read", 64'(er_under), 64'd0);
        checkOutput("sift over-read", 64'(sift_under), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
